// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one single-port, variable-latency memory bus
// between the fetch port (IM) and the data port (DM).
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   im_rd_i/im_addr_i   fetch request (held until im_valid_o) and address
//   im_data_o           fetched word, valid with the im_valid_o pulse
//   im_valid_o          one-cycle fetch completion pulse
//   dm_load_i/_store_i  data request (held until dm_ready_o)
//   dm_addr_i           data address
//   dm_data_s_i         store data
//   dm_data_select_i    store byte enables
//   dm_data_l_o         load data, valid with dm_ready_o for a load
//   dm_ready_o          one-cycle data completion pulse
//   mem_req_o           bus request, held until mem_ack_i
//   mem_we_o            bus write enable
//   mem_addr_o          bus address
//   mem_data_o          bus write data
//   mem_sel_o           bus byte enables
//   mem_ack_i           bus completion, read data valid in the same cycle
//   mem_data_i          bus read data
//
// DM has priority.  While IM is waiting, a saturating counter tracks
// back-to-back DM grants; once it reaches g_dm_max_consecutive the next
// grant goes to IM.  Legal range of g_dm_max_consecutive is 1..255.

module rv_mem_arbiter #(
    parameter int unsigned g_dm_max_consecutive = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        im_rd_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,

    input  logic        dm_load_i,
    input  logic        dm_store_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_ready_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        IM_BUS,
        DM_BUS,
        RESP
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(g_dm_max_consecutive);

    state_t     state;
    logic [7:0] cnt;

    logic dm_pend;
    logic grant_im;
    logic grant_dm;

    // Grant decision, only acted upon in IDLE.
    always_comb begin
        dm_pend  = dm_load_i | dm_store_i;
        grant_im = im_rd_i & (~dm_pend | (cnt == CNT_MAX));
        grant_dm = dm_pend & ~grant_im;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_sel_o   <= '0;
            im_data_o   <= '0;
            im_valid_o  <= 1'b0;
            dm_data_l_o <= '0;
            dm_ready_o  <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle (the RESP cycle).
            im_valid_o <= 1'b0;
            dm_ready_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_im) begin
                        state      <= IM_BUS;
                        cnt        <= '0;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= im_addr_i;
                        mem_data_o <= '0;
                        mem_sel_o  <= 4'hF;
                    end else if (grant_dm) begin
                        state      <= DM_BUS;
                        mem_req_o  <= 1'b1;
                        // Load and store together is served as a store.
                        mem_we_o   <= dm_store_i;
                        mem_addr_o <= dm_addr_i;
                        mem_data_o <= dm_data_s_i;
                        mem_sel_o  <= dm_store_i ? dm_data_select_i
                                                 : 4'hF;
                        // Count only the DM grants that made IM wait.
                        if (im_rd_i) begin
                            if (cnt != CNT_MAX) begin
                                cnt <= cnt + 8'd1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                end

                IM_BUS: begin
                    if (mem_ack_i) begin
                        state      <= RESP;
                        mem_req_o  <= 1'b0;
                        im_data_o  <= mem_data_i;
                        im_valid_o <= 1'b1;
                    end
                end

                DM_BUS: begin
                    if (mem_ack_i) begin
                        state      <= RESP;
                        mem_req_o  <= 1'b0;
                        dm_ready_o <= 1'b1;
                        if (!mem_we_o) begin
                            dm_data_l_o <= mem_data_i;
                        end
                    end
                end

                RESP: begin
                    // Requests still held during the done cycle are
                    // ignored here so they are never served twice.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed stimulus with a queue-based scoreboard
// for rv_mem_arbiter; a monitor compares bus and completion traffic.

module tb_rv_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        im_rd_i = 1'b0;
    logic [31:0] im_addr_i = '0;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic        dm_load_i = 1'b0;
    logic        dm_store_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_data_s_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic [31:0] dm_data_l_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i = '0;

    rv_mem_arbiter #(.g_dm_max_consecutive(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .im_rd_i          (im_rd_i),
        .im_addr_i        (im_addr_i),
        .im_data_o        (im_data_o),
        .im_valid_o       (im_valid_o),
        .dm_load_i        (dm_load_i),
        .dm_store_i       (dm_store_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_data_l_o      (dm_data_l_o),
        .dm_ready_o       (dm_ready_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_sel_o        (mem_sel_o),
        .mem_ack_i        (mem_ack_i),
        .mem_data_i       (mem_data_i)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          hold;
    } bus_t;

    typedef struct {
        logic        is_im;
        logic [31:0] data;
        int          lat;
    } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int exp_bus_n = 0;
    int exp_done_n = 0;
    int bus_seen = 0;
    int done_seen = 0;
    int hold_cnt = 0;
    logic prev_req = 1'b0;

    logic [31:0] rd_key = '0;
    logic [31:0] exp_dl = '0;
    int   ack_wait = 0;
    int   waits = 0;
    logic slave_en = 1'b1;
    logic slave_ack = 1'b0;
    logic force_ack = 1'b0;

    assign mem_ack_i = slave_ack | force_ack;

    always @(posedge clk_i) cyc++;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void fail_evt(string name);
        n_total++;
        $display("FAIL %s", name);
    endfunction

    function automatic void push_bus(logic we, logic [31:0] a,
                                     logic [31:0] d, logic [3:0] s,
                                     int hold);
        bus_q.push_back('{we: we, addr: a, data: d, sel: s, hold: hold});
        exp_bus_n++;
    endfunction

    function automatic void push_done(logic is_im, logic [31:0] d,
                                      int lat);
        done_q.push_back('{is_im: is_im, data: d, lat: lat});
        exp_done_n++;
    endfunction

    // Bus slave: acks after ack_wait wait cycles, read data = key ^ addr.
    always @(negedge clk_i) begin
        mem_data_i = rd_key ^ mem_addr_o;
        if (slave_en && mem_req_o) begin
            if (waits == ack_wait) begin
                slave_ack = 1'b1;
                waits = 0;
            end else begin
                slave_ack = 1'b0;
                waits++;
            end
        end else begin
            slave_ack = 1'b0;
            waits = 0;
        end
    end

    // Monitor: bus transactions and completion pulses against queues.
    always @(negedge clk_i) begin
        if (mem_req_o) begin
            if (!prev_req) bus_seen++;
            if (bus_q.size() == 0) begin
                if (!prev_req) fail_evt("bus_unexpected");
            end else begin
                check("bus_we", 32'(mem_we_o), 32'(bus_q[0].we));
                check("bus_addr", mem_addr_o, bus_q[0].addr);
                check("bus_sel", 32'(mem_sel_o), 32'(bus_q[0].sel));
                if (bus_q[0].we)
                    check("bus_data", mem_data_o, bus_q[0].data);
            end
            hold_cnt++;
        end else if (prev_req) begin
            if (bus_q.size() > 0) begin
                bus_t e;
                e = bus_q.pop_front();
                if (e.hold != 0) check("bus_hold", 32'(hold_cnt), 32'(e.hold));
            end
            hold_cnt = 0;
        end
        prev_req = mem_req_o;

        if (im_valid_o && dm_ready_o) fail_evt("both_done");
        if (im_valid_o || dm_ready_o) begin
            done_seen++;
            if (done_q.size() == 0) begin
                fail_evt("done_unexpected");
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("done_port", 32'(im_valid_o), 32'(d.is_im));
                if (d.is_im) check("im_data", im_data_o, d.data);
                else check("dm_data_l", dm_data_l_o, d.data);
                if (d.lat != 0)
                    check("done_latency", 32'(cyc - issue_cyc), 32'(d.lat));
            end
        end
    end

    task automatic im_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            im_rd_i = 1'b1;
            im_addr_i = base + 32'(4 * i);
            do begin
                @(negedge clk_i);
                t++;
            end while (!im_valid_o && t < 200);
            if (!im_valid_o) fail_evt("im_timeout");
        end
        im_rd_i = 1'b0;
    endtask

    // mode: 0 load, 1 store, 2 load+store together
    task automatic dm_run(input int mode, input logic [31:0] base,
                          input logic [31:0] wdata,
                          input logic [3:0] sel, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            dm_load_i = (mode != 1);
            dm_store_i = (mode != 0);
            dm_addr_i = base + 32'(4 * i);
            dm_data_s_i = wdata;
            dm_data_select_i = sel;
            do begin
                @(negedge clk_i);
                t++;
            end while (!dm_ready_o && t < 200);
            if (!dm_ready_o) fail_evt("dm_timeout");
        end
        dm_load_i = 1'b0;
        dm_store_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_dl = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_im_valid", 32'(im_valid_o), 32'd0);
        check("rst_dm_ready", 32'(dm_ready_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_data_o, 32'd0);
        check("rst_sel", 32'(mem_sel_o), 32'd0);
        check("rst_im_data", im_data_o, 32'd0);
        check("rst_dm_data", dm_data_l_o, 32'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Single fetch, ack in the first request cycle.
        rd_key = 32'hDEADBFEF;
        ack_wait = 0;
        push_bus(1'b0, 32'h100, 32'h0, 4'hF, 1);
        push_done(1'b1, 32'hDEADBEEF, 2);
        issue_cyc = cyc;
        im_run(32'h100, 1);
        repeat (2) @(negedge clk_i);

        // Misaligned store, three wait cycles.
        ack_wait = 3;
        push_bus(1'b1, 32'h2002, 32'h00AB00AB, 4'b1100, 4);
        push_done(1'b0, 32'h0, 5);
        issue_cyc = cyc;
        dm_run(1, 32'h2002, 32'h00AB00AB, 4'b1100, 1);
        repeat (2) @(negedge clk_i);

        // Load, one wait cycle.
        rd_key = 32'h5A5A0000;
        ack_wait = 1;
        push_bus(1'b0, 32'h3004, 32'h0, 4'hF, 2);
        push_done(1'b0, 32'h5A5A3004, 3);
        exp_dl = 32'h5A5A3004;
        issue_cyc = cyc;
        dm_run(0, 32'h3004, 32'h0, 4'h0, 1);
        repeat (2) @(negedge clk_i);

        // Load and store together: a store, load data unchanged.
        ack_wait = 0;
        push_bus(1'b1, 32'h3008, 32'h12345678, 4'b0011, 1);
        push_done(1'b0, 32'h5A5A3004, 2);
        issue_cyc = cyc;
        dm_run(2, 32'h3008, 32'h12345678, 4'b0011, 1);
        repeat (2) @(negedge clk_i);

        // Simultaneous requests: DM first, then IM.
        push_bus(1'b0, 32'h3000, 32'h0, 4'hF, 1);
        push_bus(1'b0, 32'h104, 32'h0, 4'hF, 1);
        push_done(1'b0, 32'h5A5A3000, 0);
        push_done(1'b1, 32'h5A5A0104, 0);
        exp_dl = 32'h5A5A3000;
        fork
            im_run(32'h104, 1);
            dm_run(0, 32'h3000, 32'h0, 4'h0, 1);
        join
        repeat (2) @(negedge clk_i);

        // Starvation: order D D D D I D D D D I D.
        do_reset();
        @(negedge clk_i);
        rd_key = 32'h0;
        begin
            int d;
            int m;
            d = 0;
            m = 0;
            for (int k = 0; k < 11; k++) begin
                if (k == 4 || k == 9) begin
                    push_bus(1'b0, 32'h200 + 32'(4 * m), 32'h0, 4'hF, 1);
                    push_done(1'b1, 32'h200 + 32'(4 * m), 0);
                    m++;
                end else begin
                    push_bus(1'b0, 32'h4000 + 32'(4 * d), 32'h0, 4'hF, 1);
                    push_done(1'b0, 32'h4000 + 32'(4 * d), 0);
                    d++;
                end
            end
        end
        fork
            im_run(32'h200, 2);
            dm_run(0, 32'h4000, 32'h0, 4'h0, 9);
        join
        repeat (2) @(negedge clk_i);

        // Reset while in DM_BUS; late ack must be discarded.
        slave_en = 1'b0;
        push_bus(1'b0, 32'h5000, 32'h0, 4'hF, 0);
        dm_load_i = 1'b1;
        dm_addr_i = 32'h5000;
        repeat (3) @(negedge clk_i);
        check("req_before_reset", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        dm_load_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_dl = '0;
        check("req_after_reset", 32'(mem_req_o), 32'd0);
        force_ack = 1'b1;
        @(negedge clk_i);
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("late_ack_req", 32'(mem_req_o), 32'd0);
            check("late_ack_ready", 32'(dm_ready_o), 32'd0);
        end
        slave_en = 1'b1;

        // Recovery fetch after the abandoned transaction.
        rd_key = 32'hC0DE0000;
        ack_wait = 2;
        push_bus(1'b0, 32'h300, 32'h0, 4'hF, 3);
        push_done(1'b1, 32'hC0DE0300, 4);
        issue_cyc = cyc;
        im_run(32'h300, 1);
        repeat (4) @(negedge clk_i);

        check("bus_q_left", 32'(bus_q.size()), 32'd0);
        check("done_q_left", 32'(done_q.size()), 32'd0);
        check("bus_count", 32'(bus_seen), 32'(exp_bus_n));
        check("done_count", 32'(done_seen), 32'(exp_done_n));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
